// File: rtl/id_stage_if.sv
// Handshake and ID/EX bus between fetch, the decode stage and execute.
// slave is the decode stage; master is the fetch/execute side driving it.
interface id_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc;
  logic              flush;
  logic              ex_ready;

  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_wb_addr;
  logic              id_regWrite;
  logic              id_memRead;
  logic              id_memWrite;
  logic              id_aluSrc;
  logic [3:0]        id_aluOp;
  logic [DATA_W-1:0] id_imm;
  logic [1:0]        id_branch;
  logic              id_jump;
  logic              id_illegal;
  logic [31:0]       id_count;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_pc, id_rs, id_rt, id_wb_addr, id_regWrite,
           id_memRead, id_memWrite, id_aluSrc, id_aluOp, id_imm, id_branch,
           id_jump, id_illegal, id_count
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_pc, id_rs, id_rt, id_wb_addr, id_regWrite,
           id_memRead, id_memWrite, id_aluSrc, id_aluOp, id_imm, id_branch,
           id_jump, id_illegal, id_count
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the fetched word and holds it in the ID/EX
// register, with stall on ex_ready, flush, and load-use bubble insertion.
module id_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  id_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] wb_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] imm;
    logic [1:0]        branch;
    logic              jump;
    logic              illegal;
  } entry_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25,
                         FN_SLT = 6'h2A;

  logic [DATA_W-1:0] instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign instr    = bus.if_instr;
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = DATA_W'($signed(instr[15:0]));
  assign imm_zext = DATA_W'(instr[15:0]);

  entry_t dec;
  logic   dec_wr;
  logic   dec_reads_rt;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec          = '0;
    dec_wr       = 1'b0;
    dec.pc       = bus.if_pc;
    dec.rs       = ADDR_W'(instr[25:21]);
    dec.rt       = ADDR_W'(instr[20:16]);
    dec_reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ)   || (opcode == OP_BNE);
    case (opcode)
      OP_RTYPE: begin
        dec.wb_addr = ADDR_W'(instr[15:11]);
        dec_wr      = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            dec.alu_op  = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            dec.alu_src = 1'b1;
            dec.imm     = DATA_W'(instr[10:6]);
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        dec.wb_addr  = dec.rt;
        dec_wr       = 1'b1;
        dec.alu_src  = 1'b1;
        dec.mem_read = (opcode == OP_LW);
        case (opcode)
          OP_SLTI: begin dec.alu_op = ALU_SLT; dec.imm = imm_sext; end
          OP_ANDI: begin dec.alu_op = ALU_AND; dec.imm = imm_zext; end
          OP_ORI:  begin dec.alu_op = ALU_OR;  dec.imm = imm_zext; end
          OP_LUI:  begin dec.alu_op = ALU_LUI; dec.imm = DATA_W'({instr[15:0], 16'h0000}); end
          default: begin dec.alu_op = ALU_ADD; dec.imm = imm_sext; end
        endcase
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.imm       = imm_sext;
        dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_sext;
        dec.branch = (opcode == OP_BEQ) ? 2'd1 : 2'd2;
      end
      OP_J: begin
        dec.jump = 1'b1;
        dec.imm  = DATA_W'(instr[25:0]);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.wb_addr = '0;
      dec_wr      = 1'b0;
    end
    dec.reg_write = dec_wr && (dec.wb_addr != '0);
  end

  // An entry that is not a real instruction must not carry side-effecting controls.
  function automatic entry_t kill(input entry_t e);
    entry_t k;
    k           = e;
    k.reg_write = 1'b0;
    k.mem_read  = 1'b0;
    k.mem_write = 1'b0;
    k.branch    = 2'd0;
    k.jump      = 1'b0;
    k.illegal   = 1'b0;
    return k;
  endfunction

  entry_t      entry_q, entry_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        adv;
  logic        haz;

  assign adv = !valid_q || bus.ex_ready;
  assign haz = HAZARD_EN && valid_q && entry_q.mem_read && (entry_q.wb_addr != '0) &&
               ((dec.rs == entry_q.wb_addr) ||
                (dec_reads_rt && (dec.rt == entry_q.wb_addr)));
  assign bus.if_ready = adv && !haz && !bus.flush;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    count_d = count_q;
    if (valid_q && bus.ex_ready && !bus.flush) count_d = count_q + 32'd1;
    if (bus.flush || (adv && haz)) begin
      valid_d = 1'b0;
      entry_d = kill(entry_q);
    end else if (adv) begin
      valid_d = bus.if_valid;
      entry_d = bus.if_valid ? dec : kill(dec);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.id_valid    = valid_q;
  assign bus.id_pc       = entry_q.pc;
  assign bus.id_rs       = entry_q.rs;
  assign bus.id_rt       = entry_q.rt;
  assign bus.id_wb_addr  = entry_q.wb_addr;
  assign bus.id_regWrite = entry_q.reg_write;
  assign bus.id_memRead  = entry_q.mem_read;
  assign bus.id_memWrite = entry_q.mem_write;
  assign bus.id_aluSrc   = entry_q.alu_src;
  assign bus.id_aluOp    = entry_q.alu_op;
  assign bus.id_imm      = entry_q.imm;
  assign bus.id_branch   = entry_q.branch;
  assign bus.id_jump     = entry_q.jump;
  assign bus.id_illegal  = entry_q.illegal;
  assign bus.id_count    = count_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed literal scenarios plus random traffic
// compared every cycle against an instruction-level reference model.
module tb_id_stage;

  localparam logic [31:0] I_ADD    = 32'h014B4820; // add $t1,$t2,$t3
  localparam logic [31:0] I_LW     = 32'h8E08FFFC; // lw  $t0,-4($s0)
  localparam logic [31:0] I_ADD_T0 = 32'h01084820; // add $t1,$t0,$t0
  localparam logic [31:0] I_ILL    = 32'hFC000000; // opcode 0x3F
  localparam logic [31:0] I_ADDI0  = 32'h20000005; // addi $0,$0,5

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  id_stage #(.DATA_W(32), .ADDR_W(5), .HAZARD_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rs, rt, wb;
    logic        rw, mr, mw, src, jmp, ill, reads_rt;
    logic [3:0]  op;
    logic [1:0]  br;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t        d;
    logic [5:0]  op = w[31:26];
    logic [5:0]  fn = w[5:0];
    logic [31:0] sx = {{16{w[15]}}, w[15:0]};
    logic [31:0] zx = {16'h0000, w[15:0]};
    d = '0;
    d.rs = w[25:21];
    d.rt = w[20:16];
    d.reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    if (op == 6'h00) begin
      d.ill = 1'b0;
      if      (fn == 6'h20) d.op = 4'd0;
      else if (fn == 6'h22) d.op = 4'd1;
      else if (fn == 6'h24) d.op = 4'd2;
      else if (fn == 6'h25) d.op = 4'd3;
      else if (fn == 6'h2A) d.op = 4'd4;
      else if (fn == 6'h00) begin d.op = 4'd5; d.src = 1'b1; d.imm = {27'd0, w[10:6]}; end
      else if (fn == 6'h02) begin d.op = 4'd6; d.src = 1'b1; d.imm = {27'd0, w[10:6]}; end
      else d.ill = 1'b1;
      if (!d.ill) d.wb = w[15:11];
    end
    else if (op == 6'h08) begin d.src = 1; d.imm = sx; d.wb = w[20:16]; end
    else if (op == 6'h0A) begin d.src = 1; d.imm = sx; d.wb = w[20:16]; d.op = 4'd4; end
    else if (op == 6'h0C) begin d.src = 1; d.imm = zx; d.wb = w[20:16]; d.op = 4'd2; end
    else if (op == 6'h0D) begin d.src = 1; d.imm = zx; d.wb = w[20:16]; d.op = 4'd3; end
    else if (op == 6'h0F) begin d.src = 1; d.imm = {w[15:0], 16'h0}; d.wb = w[20:16]; d.op = 4'd7; end
    else if (op == 6'h23) begin d.src = 1; d.imm = sx; d.wb = w[20:16]; d.mr = 1; end
    else if (op == 6'h2B) begin d.src = 1; d.imm = sx; d.mw = 1; end
    else if (op == 6'h04) begin d.imm = sx; d.op = 4'd1; d.br = 2'd1; end
    else if (op == 6'h05) begin d.imm = sx; d.op = 4'd1; d.br = 2'd2; end
    else if (op == 6'h02) begin d.jmp = 1; d.imm = {6'd0, w[25:0]}; end
    else d.ill = 1'b1;
    d.rw = (d.wb != 5'd0);
    return d;
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  dec_t        m_d     = '0;
  logic [31:0] m_count = '0;

  function automatic logic m_haz(input logic [31:0] w);
    dec_t n = ref_decode(w);
    return m_valid && m_d.mr && (m_d.wb != 5'd0) &&
           ((n.rs == m_d.wb) || (n.reads_rt && (n.rt == m_d.wb)));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_d     <= '0;
      m_count <= '0;
    end else begin
      if (m_valid && bus.ex_ready && !bus.flush) m_count <= m_count + 1;
      if (bus.flush) m_valid <= 1'b0;
      else if (!m_valid || bus.ex_ready) begin
        if (m_haz(bus.if_instr)) m_valid <= 1'b0;
        else begin
          m_valid <= bus.if_valid;
          m_pc    <= bus.if_pc;
          m_d     <= ref_decode(bus.if_instr);
        end
      end
    end
  end

  // Compare process: outputs settle after the negedge input update.
  always @(negedge clk) begin
    logic exp_rdy;
    #2;
    exp_rdy = (!m_valid || bus.ex_ready) && !m_haz(bus.if_instr) && !bus.flush;
    check("if_ready", bus.if_ready, exp_rdy);
    check("ctrl", {bus.id_valid, bus.id_regWrite, bus.id_memRead, bus.id_memWrite,
                   bus.id_jump, bus.id_branch},
          m_valid ? {1'b1, m_d.rw, m_d.mr, m_d.mw, m_d.jmp, m_d.br} : 7'd0);
    check("id_count", bus.id_count, m_count);
    if (m_valid) begin
      check("fields", {bus.id_rs, bus.id_rt, bus.id_wb_addr, bus.id_aluSrc, bus.id_aluOp, bus.id_illegal},
            {m_d.rs, m_d.rt, m_d.wb, m_d.src, m_d.op, m_d.ill});
      check("id_pc", bus.id_pc, m_pc);
      check("id_imm", bus.id_imm, m_d.imm);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic fl, input logic exr);
    @(negedge clk);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.flush    = fl;
    bus.ex_ready = exr;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs = 5'($urandom_range(0, 3));
    logic [4:0]  rt = 5'($urandom_range(0, 3));
    logic [4:0]  rd = 5'($urandom_range(0, 3));
    logic [4:0]  sh = 5'($urandom);
    logic [15:0] imm = 16'($urandom);
    fn = 6'h20;
    case ($urandom_range(0, 15))
      0, 1, 2, 3: begin
        op = 6'h00;
        case ($urandom_range(0, 7))
          0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;  3: fn = 6'h25;
          4: fn = 6'h2A;  5: fn = 6'h00;  6: fn = 6'h02;
          default: fn = 6'($urandom);
        endcase
      end
      4:       op = 6'h08;
      5:       op = 6'h0A;
      6:       op = 6'h0C;
      7:       op = 6'h0D;
      8:       op = 6'h0F;
      9, 10:   op = 6'h23;
      11:      op = 6'h2B;
      12:      op = 6'h04;
      13:      op = 6'h05;
      14:      op = 6'h02;
      default: op = 6'($urandom);
    endcase
    if (op == 6'h00) return {op, rs, rt, rd, sh, fn};
    return {op, rs, rt, imm};
  endfunction

  initial begin
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset mid-stream
    put(1, I_ADD, 32'h100, 0, 1);
    put(1, I_ADD, 32'h104, 0, 1);
    put(0, 32'h0, 32'h0, 0, 0);
    #3;
    check("pre_reset_valid", bus.id_valid, 1);
    check("pre_reset_count", bus.id_count, 1);
    reset = 1'b1;
    #1;
    check("async_reset_valid", bus.id_valid, 0);
    put(0, 32'h0, 32'h0, 0, 1);
    reset = 1'b0;
    #3;
    check("rst_valid", bus.id_valid, 0);
    check("rst_count", bus.id_count, 0);
    check("rst_pc", bus.id_pc, 0);
    check("rst_regs", {bus.id_rs, bus.id_rt, bus.id_wb_addr}, 0);
    check("rst_imm", bus.id_imm, 0);
    check("rst_aluop", bus.id_aluOp, 0);
    check("rst_if_ready", bus.if_ready, 1);

    // add $t1,$t2,$t3
    put(1, I_ADD, 32'h200, 0, 1);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("add_valid", bus.id_valid, 1);
    check("add_rs", bus.id_rs, 10);
    check("add_rt", bus.id_rt, 11);
    check("add_wb", bus.id_wb_addr, 9);
    check("add_regwrite", bus.id_regWrite, 1);
    check("add_aluop", bus.id_aluOp, 0);

    // lw then dependent add: one bubble
    put(1, I_LW, 32'h300, 0, 1);
    put(1, I_ADD_T0, 32'h304, 0, 1);
    #3;
    check("lw_valid", bus.id_valid, 1);
    check("lw_imm", bus.id_imm, 32'hFFFFFFFC);
    check("lw_memread", bus.id_memRead, 1);
    check("lw_use_if_ready", bus.if_ready, 0);
    check("lw_count", bus.id_count, 1);
    put(1, I_ADD_T0, 32'h304, 0, 1);
    #3;
    check("bubble_valid", bus.id_valid, 0);
    check("bubble_if_ready", bus.if_ready, 1);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("dep_add_valid", bus.id_valid, 1);
    check("dep_add_pc", bus.id_pc, 32'h304);
    check("dep_add_rs", bus.id_rs, 8);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("lw_use_count", bus.id_count, 3);

    // Hold for 3 cycles of ex_ready=0
    put(1, I_ADD, 32'h400, 0, 1);
    for (int i = 0; i < 3; i++) begin
      put(1, I_ADD_T0, 32'h404, 0, 0);
      #3;
      check("hold_pc", bus.id_pc, 32'h400);
      check("hold_if_ready", bus.if_ready, 0);
    end
    put(1, I_ADD_T0, 32'h404, 0, 1);
    #3;
    check("release_pc", bus.id_pc, 32'h400);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("next_pc", bus.id_pc, 32'h404);
    check("next_valid", bus.id_valid, 1);

    // Flush together with if_valid
    put(1, I_ADD, 32'h500, 0, 1);
    put(1, I_ADD, 32'h504, 1, 1);
    #3;
    check("flush_if_ready", bus.if_ready, 0);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("flush_valid", bus.id_valid, 0);
    check("flush_count", bus.id_count, 5);

    // Illegal opcode and write to $0
    put(1, I_ILL, 32'h600, 0, 1);
    put(1, I_ADDI0, 32'h700, 0, 1);
    #3;
    check("ill_flag", bus.id_illegal, 1);
    check("ill_regwrite", bus.id_regWrite, 0);
    put(0, 32'h0, 32'h0, 0, 1);
    #3;
    check("addi0_wb", bus.id_wb_addr, 0);
    check("addi0_regwrite", bus.id_regWrite, 0);
    check("addi0_imm", bus.id_imm, 5);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 3) != 0, rand_instr(), $urandom,
          $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
      if (i == 1500) reset = 1'b1;
      if (i == 1502) reset = 1'b0;
    end
    put(0, 32'h0, 32'h0, 0, 1);
    repeat (2) @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
